eight_input_debouncer: RTL and testbench
========================================

Name: eight_input_debouncer

Overview:
- Upstream conditioning stage for the 8-to-3 encoder.
- Takes eight raw, asynchronous switch/button lines and synchronises and debounces each one independently.
- Drives clean, stable levels whose bus feeds the encoder's 8-bit input directly.
- Also provides per-channel one-cycle rise/fall strobes and an any-active flag for downstream control logic.

Parameters:
- WIDTH, 8, number of input channels; the encoder requires 8.
- STABLE_CYCLES, 50000, consecutive clk cycles a synchronised input must differ from the stable level before the stable level is updated; legal range 1 to 2^CNT_W.
- CNT_W, 16, width of each per-channel debounce counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- raw_in  input  WIDTH  raw, unsynchronised switch levels; bit i feeds encoder input i.
- sw_out  output  WIDTH  debounced stable levels, registered; connects to the encoder's eight_input.
- rise  output  WIDTH  one-cycle pulse on bit i when sw_out[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse on bit i when sw_out[i] goes 1->0.
- any_on  output  1  registered OR of the next sw_out value; equals |sw_out every cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: while rst=1, all registers are cleared immediately, independent of clk:
  - sync stage 1, sync stage 2, all counters, sw_out, rise, fall and any_on are 0.
  - Reset is released synchronously in the sense that the first update is the first clk edge with rst=0.
- Synchroniser: per bit, a two-flop chain sync1 <= raw_in[i], sync2 <= sync1. Raw glitches shorter than one cycle may or may not be captured; the debounce filter absorbs them.
- Per-channel filter, evaluated at every clk edge:
  - sync2 == sw_out[i]: cnt <= 0; rise[i] <= 0; fall[i] <= 0.
  - sync2 != sw_out[i] and cnt < STABLE_CYCLES-1: cnt <= cnt+1; no output change; strobes 0.
  - sync2 != sw_out[i] and cnt == STABLE_CYCLES-1: sw_out[i] <= sync2; cnt <= 0; rise[i] <= sync2; fall[i] <= ~sync2.
- Bounce handling: any return of sync2 to the stable level before the threshold clears the counter. Partial counts never carry over.
- Latency: raw_in[i] changes and holds from before edge k, then sw_out[i] updates at edge k+STABLE_CYCLES+1. With STABLE_CYCLES=1, this is edge k+2 (synchroniser latency only).
- Strobes: high for exactly the cycle following the sw_out update edge. Each strobe is at most one cycle wide, and rise[i] and fall[i] are never high together.
- Independence: channels are fully independent. Several channels may update at the same edge, each producing its own strobe.
- any_on: registered at the same edge as sw_out, from the next-state value, so it tracks |sw_out with zero cycle offset.
- Counter: cannot exceed STABLE_CYCLES-1, so no wrap-around.
- Reset mid-operation: partial counts and the stable state are discarded. After release, inputs held at 1 need the full STABLE_CYCLES+2 edges to appear on sw_out; no strobe is emitted during reset.
- Encoder contract: consumers must use sw_out only. Multiple simultaneously active bits are passed through unchanged; priority resolution belongs to the encoder.

Test Plan (STABLE_CYCLES=4, CNT_W=3):
- Reset: assert rst with raw_in=8'hFF mid-cycle -> all outputs 0 before the next edge. Release and hold 8'hFF -> sw_out=8'hFF, rise=8'hFF for one cycle and any_on=1, all at the 6th edge after release.
- Clean press: raw_in 8'h00->8'h04 before edge 0 -> sw_out=8'h04 and rise=8'h04 at edge 5. rise=0 at edge 6; fall stays 0.
- Bounce: raw_in[2] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no sw_out change during toggling. Update occurs 5 edges after the final stable transition.
- Release: from sw_out=8'h04, raw_in->8'h00 -> fall=8'h04 for one cycle at edge 5; sw_out=0, any_on=0.
- Simultaneous channels: raw_in 8'h00->8'h81 -> sw_out=8'h81, rise=8'h81 at the same edge (edge 5).
- Reset mid-count: raw_in->8'h10, assert rst at edge 3 for 2 cycles -> sw_out stays 0 with no strobe. Update occurs 6 edges after release.

Source files
------------

// File: rtl/eight_input_debouncer.sv
// eight_input_debouncer
// Conditions eight raw switch/button lines for the 8-to-3 encoder. Each line is
// passed through a two-flop synchroniser and then an independent debounce filter.
// A change on a line is accepted only after the synchronised level has differed
// from the current stable level for STABLE_CYCLES consecutive clock edges.
// The block also produces one-cycle rise/fall strobes per channel and an
// any-active flag. That flag is registered from the next stable value so that
// it lines up exactly with sw_out.
module eight_input_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_on
);

    // Terminal count. When the counter reaches this value and the input still
    // differs from the stable level, the new level is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] swOut_q;
    logic [WIDTH-1:0] swOut_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             anyOn_q;
    logic             anyOn_d;

    // Two-flop synchroniser chain that brings every raw line into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync2_next(sync1_q);
        end
    end

    // Per-channel filter: count agreeing cycles, clear on any bounce back, accept at threshold
    always_comb begin
        swOut_d = swOut_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != swOut_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    swOut_d[i] = sync2_q[i];
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        anyOn_d = |swOut_d;
    end

    // Debounce counters and registered outputs, all cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            swOut_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            anyOn_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            swOut_q <= swOut_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            anyOn_q <= anyOn_d;
        end
    end

    // Second synchroniser stage is a plain copy of the first; kept as a function
    // so the chain reads as two distinct stages in the sequential block above.
    function automatic logic [WIDTH-1:0] sync2_next(input logic [WIDTH-1:0] stage1);
        return stage1;
    endfunction

    assign sw_out = swOut_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign any_on = anyOn_q;

endmodule

// File: tb/tb_eight_input_debouncer.sv
// tb_eight_input_debouncer
// Bench for eight_input_debouncer run with STABLE_CYCLES=4.
// It has three parts: a table of directed vectors checked against constant
// expectations, hand-written multi-cycle sequences for the reset and bounce
// corner cases, and a randomized run checked against a window-based
// reference model.
module tb_eight_input_debouncer;

    localparam int WIDTH  = 8;
    localparam int STABLE = 4;
    localparam int CNT_W  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] sw_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_on;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] raw;
        int         edges;
        logic [7:0] expSw;
        logic [7:0] expRise;
        logic [7:0] expFall;
        logic       expAny;
    } vec_t;

    vec_t vecs [16];

    // Reference model state. A channel flips when the last STABLE synchronised
    // samples all disagree with its stable level.
    logic [7:0] mRaw1;
    logic [7:0] mRaw2;
    logic [7:0] seenQ [$];
    logic [7:0] mSw;
    logic [7:0] mRise;
    logic [7:0] mFall;
    logic       mAny;

    eight_input_debouncer #(
        .WIDTH(WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .raw_in(raw_in),
        .sw_out(sw_out),
        .rise(rise),
        .fall(fall),
        .any_on(any_on)
    );

    // Free-running 10-time-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] expSw, input logic [7:0] expRise,
                               input logic [7:0] expFall, input logic expAny);
        checks++;
        if (sw_out !== expSw || rise !== expRise || fall !== expFall || any_on !== expAny) begin
            failures++;
            $display("[TB] FAIL %s: got sw=%h rise=%h fall=%h any=%b, expected sw=%h rise=%h fall=%h any=%b",
                     name, sw_out, rise, fall, any_on, expSw, expRise, expFall, expAny);
        end
    endtask

    // Called at a negedge: hold r for the given number of rising edges and end on a negedge
    task automatic applyStimulus(input logic [7:0] r, input int edges);
        for (int e = 0; e < edges; e++) begin
            raw_in = r;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic modelReset();
        mRaw1 = '0;
        mRaw2 = '0;
        seenQ.delete();
        mSw   = '0;
        mRise = '0;
        mFall = '0;
        mAny  = 1'b0;
    endtask

    // Advance the model by one rising edge at which raw value r was sampled
    task automatic modelStep(input logic [7:0] r);
        logic [7:0] seen;
        logic [7:0] prev;
        logic [7:0] next;
        logic       allDiffer;
        seen  = mRaw2;
        mRaw2 = mRaw1;
        mRaw1 = r;
        seenQ.push_back(seen);
        if (seenQ.size() > STABLE) begin
            void'(seenQ.pop_front());
        end
        prev = mSw;
        next = mSw;
        if (seenQ.size() == STABLE) begin
            for (int b = 0; b < 8; b++) begin
                allDiffer = 1'b1;
                for (int j = 0; j < STABLE; j++) begin
                    if (seenQ[j][b] == prev[b]) begin
                        allDiffer = 1'b0;
                    end
                end
                if (allDiffer) begin
                    next[b] = ~prev[b];
                end
            end
        end
        mRise = next & ~prev;
        mFall = ~next & prev;
        mSw   = next;
        mAny  = |next;
    endtask

    initial begin
        logic [7:0] bounce [8];
        logic [7:0] r;

        rst    = 1'b1;
        raw_in = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_idle", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;

        // Directed vectors from a clean zero state
        vecs[0]  = '{8'h04, 6, 8'h04, 8'h04, 8'h00, 1'b1};
        vecs[1]  = '{8'h04, 1, 8'h04, 8'h00, 8'h00, 1'b1};
        vecs[2]  = '{8'h04, 4, 8'h04, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{8'h00, 5, 8'h04, 8'h00, 8'h00, 1'b1};
        vecs[4]  = '{8'h00, 1, 8'h00, 8'h00, 8'h04, 1'b0};
        vecs[5]  = '{8'h00, 1, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{8'h81, 6, 8'h81, 8'h81, 8'h00, 1'b1};
        vecs[7]  = '{8'h81, 1, 8'h81, 8'h00, 8'h00, 1'b1};
        vecs[8]  = '{8'h00, 6, 8'h00, 8'h00, 8'h81, 1'b0};
        vecs[9]  = '{8'h02, 3, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{8'h00, 6, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{8'h00, 2, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{8'h02, 6, 8'h02, 8'h02, 8'h00, 1'b1};
        vecs[13] = '{8'h03, 6, 8'h03, 8'h01, 8'h00, 1'b1};
        vecs[14] = '{8'h01, 6, 8'h01, 8'h00, 8'h02, 1'b1};
        vecs[15] = '{8'h00, 6, 8'h00, 8'h00, 8'h01, 1'b0};
        for (int v = 0; v < 16; v++) begin
            applyStimulus(vecs[v].raw, vecs[v].edges);
            checkOutput($sformatf("vec%0d", v), vecs[v].expSw, vecs[v].expRise, vecs[v].expFall, vecs[v].expAny);
        end

        // Bounce on bit 2: toggling in pairs never reaches the threshold
        bounce = '{8'h04, 8'h04, 8'h00, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(bounce[k], 1);
            checkOutput("bounce_hold", 8'h00, 8'h00, 8'h00, 1'b0);
        end
        applyStimulus(8'h04, 5);
        checkOutput("bounce_edge4", 8'h00, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h04, 1);
        checkOutput("bounce_edge5", 8'h04, 8'h04, 8'h00, 1'b1);

        // Asynchronous reset mid-cycle while a rise strobe is high
        raw_in = 8'hFF;
        rst    = 1'b1;
        #1;
        checkOutput("reset_async", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_hold_ff", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(8'hFF, 1);
            checkOutput($sformatf("release_wait%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        applyStimulus(8'hFF, 1);
        checkOutput("release_edge6", 8'hFF, 8'hFF, 8'h00, 1'b1);
        applyStimulus(8'hFF, 1);
        checkOutput("release_edge7", 8'hFF, 8'h00, 8'h00, 1'b1);

        // Reset in the middle of a count discards the partial count
        raw_in = 8'h00;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h00, 3);
        applyStimulus(8'h10, 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("midcount_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(8'h10, 1);
            checkOutput($sformatf("midcount_wait%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
        end
        applyStimulus(8'h10, 1);
        checkOutput("midcount_edge6", 8'h10, 8'h10, 8'h00, 1'b1);

        // Randomized run against the reference model, with occasional resets
        raw_in = 8'h00;
        rst    = 1'b1;
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        r   = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                modelReset();
                #1;
                checkOutput("random_reset", mSw, mRise, mFall, mAny);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                case ($urandom_range(0, 11))
                    0:       r = r ^ 8'($urandom);
                    1, 2:    r = r ^ (8'h01 << $urandom_range(0, 7));
                    default: r = r;
                endcase
                raw_in = r;
                @(posedge clk);
                modelStep(r);
                @(negedge clk);
                checkOutput("random", mSw, mRise, mFall, mAny);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
